shifter_seq: RTL and testbench

Parametrised multi-cycle shift unit, successor to the single-bit combinational datapath shifter. Supports four shift/rotate modes and a multi-bit shift amount. Shifts at most STEP bit positions per clock, so a wide barrel shifter is not needed. Sits between the register-file read stage and the ALU and talks to both through valid/ready handshakes, so the pipeline controller can stall on it.

---
 rtl/shifter_seq.sv | 125 ++++++++++++
 tb/tb_shifter_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_seq.sv
// Multi-cycle shift/rotate unit: shifts up to STEP bit positions per clock
// between valid/ready handshakes on the request and result sides.
module shifter_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 5,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  logic [AMT_W-1:0] r_rem;

  logic [WIDTH-1:0] w_data;
  logic             w_carry;
  logic [AMT_W-1:0] w_sub;

  // Positions consumed this clock: min(remaining, STEP)
  always_comb begin
    w_sub = r_rem;
    if (32'(r_rem) >= STEP) begin
      w_sub = AMT_W'(STEP);
    end
  end

  // Unrolled chain of single-bit steps; only the first w_sub stages are active
  always_comb begin
    w_data  = r_data;
    w_carry = r_carry;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < 32'(w_sub)) begin
        case (r_op)
          OP_LSL: begin
            w_carry = w_data[WIDTH-1];
            w_data  = {w_data[WIDTH-2:0], 1'b0};
          end
          OP_LSR: begin
            w_carry = w_data[0];
            w_data  = {1'b0, w_data[WIDTH-1:1]};
          end
          OP_ASR: begin
            w_carry = w_data[0];
            w_data  = {w_data[WIDTH-1], w_data[WIDTH-1:1]};
          end
          default: begin
            w_carry = w_data[0];
            w_data  = {w_data[0], w_data[WIDTH-1:1]};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LSL;
      r_data  <= '0;
      r_carry <= 1'b0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= op_t'(in_op);
            r_data  <= in_data;
            r_carry <= 1'b0;
            r_rem   <= in_amt;
            r_state <= (in_amt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_data  <= w_data;
          r_carry <= w_carry;
          r_rem   <= r_rem - w_sub;
          if (r_rem == w_sub) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_data;
  assign out_carry = r_carry;
  assign out_zero  = (r_data == '0);
  assign out_neg   = r_data[WIDTH-1];

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq: directed cases, backpressure, reset abort
// and randomized transactions against an arithmetic reference model.
module tb_shifter_seq;

  localparam int unsigned W     = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned STEPS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_op;
  logic [AW-1:0] in_amt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;
  logic          out_neg;

  int n_pass  = 0;
  int n_total = 0;

  shifter_seq #(.WIDTH(W), .AMT_W(AW), .STEP(STEPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: whole-operation result from shift arithmetic, not step iteration
  function automatic void model(input logic [W-1:0] d, input logic [1:0] op, input int amt,
                                output logic [W-1:0] r, output logic c);
    logic signed [W-1:0] sd;
    int k;
    sd = d;
    r  = d;
    c  = 1'b0;
    case (op)
      2'b00: begin
        r = d << amt;
        if (amt != 0 && amt <= int'(W)) c = d[int'(W) - amt];
      end
      2'b01: begin
        r = d >> amt;
        if (amt != 0 && amt <= int'(W)) c = d[amt - 1];
      end
      2'b10: begin
        r = sd >>> amt;
        if (amt != 0) c = (amt <= int'(W)) ? d[amt - 1] : d[W-1];
      end
      default: begin
        k = amt % int'(W);
        r = (d >> k) | (d << (int'(W) - k));
        if (amt != 0) c = r[W-1];
      end
    endcase
  endfunction

  // Runs one request through the unit, scrambling inputs while it is busy
  task automatic do_txn(input logic [W-1:0] d, input logic [1:0] op, input logic [AW-1:0] amt,
                        output int lat, output bit to, output logic rdy_acc, output logic rdy_hand,
                        output logic [W-1:0] rd, output logic rc, output logic rz, output logic rn);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_op = op; in_amt = amt;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_acc  = in_ready;
    lat = 0;
    to  = 1'b0;
    while (!out_valid && !to) begin
      in_valid = 1'(($urandom & 1));
      in_data  = W'($urandom);
      in_op    = 2'($urandom);
      in_amt   = AW'($urandom);
      @(posedge clk); #1;
      lat++;
      if (lat > 100) to = 1'b1;
    end
    in_valid = 1'b0;
    rd = out_data; rc = out_carry; rz = out_zero; rn = out_neg;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rdy_hand  = in_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({in_ready, out_valid, out_data, out_carry, out_zero, out_neg} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h c=%b z=%b n=%b, want 1 0 0000 0 1 0",
               in_ready, out_valid, out_data, out_carry, out_zero, out_neg);
    end else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0]  td [5] = '{16'h8001, 16'h8000, 16'h1234, 16'h0001, 16'h00F0};
    logic [1:0]    top [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b01};
    logic [AW-1:0] tamt [5] = '{5'd1, 5'd15, 5'd20, 5'd17, 5'd0};
    logic [W-1:0]  xd [5] = '{16'h0002, 16'hFFFF, 16'h4123, 16'h0000, 16'h00F0};
    logic          xc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int            xl [5] = '{1, 4, 5, 5, 0};
    int lat; bit to; logic ra, rh, rc, rz, rn; logic [W-1:0] rd;
    for (int i = 0; i < 5; i++) begin
      do_txn(td[i], top[i], tamt[i], lat, to, ra, rh, rd, rc, rz, rn);
      n_total++;
      if (to !== 1'b0) $display("FAIL dir%0d_timeout: out_valid never rose", i);
      else n_pass++;
      n_total++;
      if (lat !== xl[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, xl[i]);
      else n_pass++;
      n_total++;
      if ({rd, rc} !== {xd[i], xc[i]})
        $display("FAIL dir%0d_result: got data=%h c=%b want data=%h c=%b", i, rd, rc, xd[i], xc[i]);
      else n_pass++;
      n_total++;
      if ({rz, rn} !== {xd[i] == '0, xd[i][W-1]})
        $display("FAIL dir%0d_flags: got z=%b n=%b want z=%b n=%b", i, rz, rn, xd[i] == '0, xd[i][W-1]);
      else n_pass++;
      n_total++;
      if ({ra, rh} !== 2'b01)
        $display("FAIL dir%0d_ready: got after_accept=%b after_handoff=%b want 0 1", i, ra, rh);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h8001; in_op = 2'b00; in_amt = 5'd1;
    @(posedge clk); #1;
    in_data = 16'h00F0; in_op = 2'b01; in_amt = 5'd0;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_total++;
      if ({out_valid, in_ready, out_data, out_carry, out_zero, out_neg} !== {1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0})
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b data=%h c=%b z=%b n=%b want 1 0 0002 1 0 0",
                 i, out_valid, in_ready, out_data, out_carry, out_zero, out_neg);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, out_data, out_carry} !== {1'b1, 16'h00F0, 1'b0})
      $display("FAIL bp_next_req: got vld=%b data=%h c=%b want 1 00f0 0", out_valid, out_data, out_carry);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int lat; bit to; logic ra, rh, rc, rz, rn; logic [W-1:0] rd;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'hFFFF; in_op = 2'b00; in_amt = 5'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_total++;
    if ({in_ready, out_valid, out_data, out_carry} !== {1'b1, 1'b0, 16'h0000, 1'b0})
      $display("FAIL rst_mid: got rdy=%b vld=%b data=%h c=%b want 1 0 0000 0", in_ready, out_valid, out_data, out_carry);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    do_txn(16'h0001, 2'b00, 5'd3, lat, to, ra, rh, rd, rc, rz, rn);
    n_total++;
    if ({to, rd, rc} !== {1'b0, 16'h0008, 1'b0})
      $display("FAIL rst_after: got to=%b data=%h c=%b want 0 0008 0", to, rd, rc);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat; bit to; logic ra, rh, rc, rz, rn; logic [W-1:0] rd, d, xd; logic xc;
    logic [1:0] op; logic [AW-1:0] amt;
    for (int i = 0; i < 60; i++) begin
      d   = W'($urandom);
      op  = 2'($urandom);
      amt = AW'($urandom);
      if (i % 8 == 0) d[W-1] = 1'b1;
      model(d, op, int'(amt), xd, xc);
      do_txn(d, op, amt, lat, to, ra, rh, rd, rc, rz, rn);
      n_total++;
      if (to !== 1'b0 || lat !== (int'(amt) + int'(STEPS) - 1) / int'(STEPS))
        $display("FAIL rnd%0d_latency: op=%0d amt=%0d got lat=%0d to=%b want %0d",
                 i, op, amt, lat, to, (int'(amt) + int'(STEPS) - 1) / int'(STEPS));
      else n_pass++;
      n_total++;
      if ({rd, rc, rz, rn} !== {xd, xc, xd == '0, xd[W-1]})
        $display("FAIL rnd%0d_result: d=%h op=%0d amt=%0d got data=%h c=%b z=%b n=%b want data=%h c=%b z=%b n=%b",
                 i, d, op, amt, rd, rc, rz, rn, xd, xc, xd == '0, xd[W-1]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
